fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives the memory's byte address combinationally. Captures the returned instruction into the IF/ID pipeline register.
- Handles decode stalls, control-flow redirects (with optional delay slot), flushes, and traps illegal fetch addresses into a sticky fault state.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_SIZE, 32'h00000800, instruction memory size in bytes; a fetch at or above this address faults.
- DELAY_SLOT, 1, 1 = instruction fetched in the redirect cycle is kept (MIPS delay slot); 0 = it is squashed.
- NOP, 32'h00000000, word loaded into the IF/ID instruction field for bubbles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode not ready; hold PC and IF/ID
- flush  in  1  replace the next IF/ID contents with a bubble
- redirect_valid  in  1  taken branch/jump resolved this cycle
- redirect_target  in  32  new PC for the redirect
- imem_address  out  32  byte address to instruction memory (= pc)
- imem_instruction  in  32  combinational read data for imem_address
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instruction  out  32  fetched word
- if_id_pc  out  32  address of if_id_instruction
- if_id_pc_plus4  out  32  if_id_pc + 4
- fetch_fault  out  1  sticky; fetch stopped on an illegal address
- fetch_fault_pc  out  32  offending PC

Behaviour:
- Clocking and reset:
  - Single clock. All state changes on the rising edge of clk.
  - reset has priority over every other input: pc=RESET_PC, pending_valid=0, pending_target=0, state=RUN, if_id_valid=0, if_id_instruction=NOP, if_id_pc=0, if_id_pc_plus4=0, fetch_fault=0, fetch_fault_pc=0.
  - Reset asserted mid-operation, including in FAULT, is handled identically.
- Memory address: imem_address = pc, combinational, zero latency. The instruction for pc is sampled on the same edge.
- Effective redirect: eff_redir = redirect_valid | pending_valid. eff_target = redirect_target if redirect_valid, else pending_target; a live redirect beats a pending one.
- Illegal PC: pc[1:0] != 0, or pc >= IMEM_SIZE (unsigned compare).
- States: RUN, FAULT.
- RUN, stall=1:
  - pc and the IF/ID fields hold.
  - If redirect_valid, latch pending_valid=1 and pending_target=redirect_target; a later redirect overwrites the pending target.
  - If flush is also asserted: if_id_valid<=0 and if_id_instruction<=NOP; the pc fields hold. Flush beats stall.
  - The illegal-PC check is not applied while stalled.
- RUN, stall=0, illegal PC:
  - state<=FAULT, fetch_fault<=1, fetch_fault_pc<=pc.
  - if_id_valid<=0, if_id_instruction<=NOP; pc holds.
- RUN, stall=0, legal PC:
  - IF/ID load: if_id_pc<=pc, if_id_pc_plus4<=pc+4 (mod 2^32), if_id_instruction<=imem_instruction, if_id_valid<=1.
  - Squash override: if flush=1, or if eff_redir=1 with DELAY_SLOT=0, then if_id_valid<=0 and if_id_instruction<=NOP; the pc fields still load.
  - Next pc <= eff_redir ? eff_target : pc+4.
  - pending_valid<=0.
- FAULT: terminal until reset.
  - pc, IF/ID and the fault outputs hold; if_id_valid stays 0.
  - stall, flush and redirect are ignored.
- Redirect to a misaligned or out-of-range target is accepted into pc; the fault fires on the next non-stalled cycle.
- Throughput: one instruction per cycle when stall=0. A stall-to-resume transition adds no bubble.

Test Plan:
- Sequential fetch: reset, memory holds words 0x11,0x22,0x33 at 0x0,0x4,0x8 -> imem_address 0,4,8 on consecutive cycles; if_id (pc,instr) = (0,0x11),(4,0x22),(8,0x33), if_id_valid=1 from the first post-reset edge.
- Stall: assert stall for 3 cycles while pc=0x8 -> imem_address stays 0x8, IF/ID holds (4,0x22); after release, IF/ID=(8,0x33) on the next edge with no lost or duplicated instruction.
- Redirect, both delay-slot settings: with pc=0x8 assert redirect_valid, target 0x40:
  - DELAY_SLOT=1 -> IF/ID=(8,0x33,valid=1), next pc=0x40.
  - DELAY_SLOT=0 -> if_id_valid=0, if_id_instruction=NOP, next pc=0x40.
- Redirect during stall: stall=1 and redirect to 0x100 in the same cycle, stall held 2 more cycles -> pc stays put; on the first unstalled edge pc=0x100 and pending clears. A second redirect to 0x200 during the stall overrides -> pc=0x200.
- Fault: redirect to 0x802 -> next unstalled edge fetch_fault=1, fetch_fault_pc=0x802, if_id_valid=0. Further redirects are ignored; pulsing reset returns pc to RESET_PC with fetch_fault=0. Repeat with 0x800 (aligned, out of range) -> same fault response.
- Flush + stall and reset priority: flush=1 with stall=1 -> if_id_valid=0, pc unchanged. reset=1 together with redirect_valid=1 -> pc=RESET_PC, all outputs at reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and captures the returned word into the IF/ID pipeline register. Handles
// decode stalls, redirects (with optional delay slot), flushes, and stops in a
// sticky fault state when it tries to fetch from an illegal address.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_SIZE  = 32'h0000_0800,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic        if_id_valid,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_pc
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pending_valid;
    logic [31:0] pending_target;

    logic        eff_redir;
    logic [31:0] eff_target;
    logic        pc_illegal;
    logic [31:0] pc_plus4;
    logic        squash;

    // Memory sees the PC directly; the word returns in the same cycle.
    assign imem_address = pc;

    // A redirect arriving this cycle takes precedence over one parked during a stall.
    always_comb begin
        eff_redir  = redirect_valid | pending_valid;
        eff_target = redirect_valid ? redirect_target : pending_target;
        pc_illegal = (pc[1:0] != 2'b00) || (pc >= IMEM_SIZE);
        pc_plus4   = pc + 32'd4;
        squash     = flush || (eff_redir && !DELAY_SLOT);
    end

    // PC, pending redirect, IF/ID register and fault tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= RUN;
            pc                <= RESET_PC;
            pending_valid     <= 1'b0;
            pending_target    <= 32'h0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP;
            if_id_pc          <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
            fetch_fault       <= 1'b0;
            fetch_fault_pc    <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        // Hold the fetch; remember a redirect so it is not lost.
                        if (redirect_valid) begin
                            pending_valid  <= 1'b1;
                            pending_target <= redirect_target;
                        end
                        if (flush) begin
                            if_id_valid       <= 1'b0;
                            if_id_instruction <= NOP;
                        end
                    end else if (pc_illegal) begin
                        state             <= FAULT;
                        fetch_fault       <= 1'b1;
                        fetch_fault_pc    <= pc;
                        if_id_valid       <= 1'b0;
                        if_id_instruction <= NOP;
                    end else begin
                        // The pc fields load even for a squashed slot so the
                        // bubble still carries a meaningful address.
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc_plus4;
                        if (squash) begin
                            if_id_valid       <= 1'b0;
                            if_id_instruction <= NOP;
                        end else begin
                            if_id_valid       <= 1'b1;
                            if_id_instruction <= imem_instruction;
                        end
                        pc            <= eff_redir ? eff_target : pc_plus4;
                        pending_valid <= 1'b0;
                    end
                end
                FAULT: begin
                    // Terminal until reset; everything holds.
                    if_id_valid <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Two instances share all inputs: one keeps
// the delay slot, the other squashes it. Each table row drives one cycle and
// pushes the expected post-edge outputs; the entry is popped and compared
// after the edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_target;

    logic [31:0] addr_ds, instr_in_ds, addr_ns, instr_in_ns;
    logic        v_ds, v_ns, flt_ds, flt_ns;
    logic [31:0] instr_ds, pc_ds, pc4_ds, fpc_ds;
    logic [31:0] instr_ns, pc_ns, pc4_ns, fpc_ns;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    assign instr_in_ds = mem_word(addr_ds);
    assign instr_in_ns = mem_word(addr_ns);

    fetch_stage #(.DELAY_SLOT(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_address(addr_ds), .imem_instruction(instr_in_ds),
        .if_id_valid(v_ds), .if_id_instruction(instr_ds), .if_id_pc(pc_ds),
        .if_id_pc_plus4(pc4_ds), .fetch_fault(flt_ds), .fetch_fault_pc(fpc_ds)
    );

    fetch_stage #(.DELAY_SLOT(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_address(addr_ns), .imem_instruction(instr_in_ns),
        .if_id_valid(v_ns), .if_id_instruction(instr_ns), .if_id_pc(pc_ns),
        .if_id_pc_plus4(pc4_ns), .fetch_fault(flt_ns), .fetch_fault_pc(fpc_ns)
    );

    typedef struct {
        logic        rst, st, fl, rv;
        logic [31:0] rt;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr, ipc, pc4;
        logic        flt;
        logic [31:0] fpc;
        logic        nv;
        logic [31:0] ninstr;
    } step_t;

    step_t steps[$];
    step_t sb[$];

    function automatic step_t mk(
        input logic rst, input logic st, input logic fl, input logic rv,
        input logic [31:0] rt, input logic [31:0] addr, input logic v,
        input logic [31:0] instr, input logic [31:0] ipc, input logic [31:0] pc4,
        input logic flt, input logic [31:0] fpc, input logic nv,
        input logic [31:0] ninstr);
        step_t s;
        s.rst = rst; s.st = st; s.fl = fl; s.rv = rv; s.rt = rt;
        s.addr = addr; s.v = v; s.instr = instr; s.ipc = ipc; s.pc4 = pc4;
        s.flt = flt; s.fpc = fpc; s.nv = nv; s.ninstr = ninstr;
        return s;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    initial begin
        step_t s, e;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;

        //                rst st fl rv target    addr    v  instr          ipc     pc4     flt fpc     nv ninstr
        // reset
        steps.push_back(mk(1, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0,         32'h0,   32'h0,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(1, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0,         32'h0,   32'h0,   0, 32'h0,   0, 32'h0));
        // sequential fetch
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h4,   1, 32'h11,        32'h0,   32'h4,   0, 32'h0,   1, 32'h11));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h8,   1, 32'h22,        32'h4,   32'h8,   0, 32'h0,   1, 32'h22));
        // stall three cycles at pc=8
        for (int i = 0; i < 3; i++)
            steps.push_back(mk(0, 1, 0, 0, 32'h0, 32'h8,  1, 32'h22,        32'h4,   32'h8,   0, 32'h0,   1, 32'h22));
        // release with a redirect to 0x40: delay slot kept vs squashed
        steps.push_back(mk(0, 0, 0, 1, 32'h40,   32'h40,  1, 32'h33,        32'h8,   32'hC,   0, 32'h0,   0, 32'h0));
        // redirect during stall, stall held two more cycles
        steps.push_back(mk(0, 1, 0, 1, 32'h100,  32'h40,  1, 32'h33,        32'h8,   32'hC,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 1, 0, 0, 32'h0,    32'h40,  1, 32'h33,        32'h8,   32'hC,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 1, 0, 0, 32'h0,    32'h40,  1, 32'h33,        32'h8,   32'hC,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h100, 1, 32'hA000_0040, 32'h40,  32'h44,  0, 32'h0,   0, 32'h0));
        // second redirect during stall overrides the first
        steps.push_back(mk(0, 1, 0, 1, 32'h180,  32'h100, 1, 32'hA000_0040, 32'h40,  32'h44,  0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 1, 0, 1, 32'h200,  32'h100, 1, 32'hA000_0040, 32'h40,  32'h44,  0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h200, 1, 32'hA000_0100, 32'h100, 32'h104, 0, 32'h0,   0, 32'h0));
        // flush + stall, then flush alone
        steps.push_back(mk(0, 1, 1, 0, 32'h0,    32'h200, 0, 32'h0,         32'h100, 32'h104, 0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 1, 0, 32'h0,    32'h204, 0, 32'h0,         32'h200, 32'h204, 0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h208, 1, 32'hA000_0204, 32'h204, 32'h208, 0, 32'h0,   1, 32'hA000_0204));
        // misaligned redirect target -> fault, then redirects ignored
        steps.push_back(mk(0, 0, 0, 1, 32'h802,  32'h802, 1, 32'hA000_0208, 32'h208, 32'h20C, 0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h802, 0, 32'h0,         32'h208, 32'h20C, 1, 32'h802, 0, 32'h0));
        steps.push_back(mk(0, 0, 1, 1, 32'h40,   32'h802, 0, 32'h0,         32'h208, 32'h20C, 1, 32'h802, 0, 32'h0));
        // reset with a simultaneous redirect
        steps.push_back(mk(1, 0, 0, 1, 32'h300,  32'h0,   0, 32'h0,         32'h0,   32'h0,   0, 32'h0,   0, 32'h0));
        // aligned but out of range; no fault while stalled
        steps.push_back(mk(0, 0, 0, 1, 32'h800,  32'h800, 1, 32'h11,        32'h0,   32'h4,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 1, 0, 0, 32'h0,    32'h800, 1, 32'h11,        32'h0,   32'h4,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h800, 0, 32'h0,         32'h0,   32'h4,   1, 32'h800, 0, 32'h0));
        steps.push_back(mk(1, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0,         32'h0,   32'h0,   0, 32'h0,   0, 32'h0));
        steps.push_back(mk(0, 0, 0, 0, 32'h0,    32'h4,   1, 32'h11,        32'h0,   32'h4,   0, 32'h0,   1, 32'h11));

        foreach (steps[i]) begin
            s = steps[i];
            reset = s.rst; stall = s.st; flush = s.fl;
            redirect_valid = s.rv; redirect_target = s.rt;
            sb.push_back(s);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check_val("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_val($sformatf("s%0d_addr", i),       addr_ds,          e.addr);
                check_val($sformatf("s%0d_valid", i),      {31'd0, v_ds},    {31'd0, e.v});
                check_val($sformatf("s%0d_instr", i),      instr_ds,         e.instr);
                check_val($sformatf("s%0d_if_pc", i),      pc_ds,            e.ipc);
                check_val($sformatf("s%0d_if_pc4", i),     pc4_ds,           e.pc4);
                check_val($sformatf("s%0d_fault", i),      {31'd0, flt_ds},  {31'd0, e.flt});
                check_val($sformatf("s%0d_fault_pc", i),   fpc_ds,           e.fpc);
                check_val($sformatf("s%0d_ns_addr", i),    addr_ns,          e.addr);
                check_val($sformatf("s%0d_ns_valid", i),   {31'd0, v_ns},    {31'd0, e.nv});
                check_val($sformatf("s%0d_ns_instr", i),   instr_ns,         e.ninstr);
                check_val($sformatf("s%0d_ns_fault", i),   {31'd0, flt_ns},  {31'd0, e.flt});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
